// File: rtl/nrs_re_extractor.sv
// nrs_re_extractor: captures the eight port-0 NRS REs of each streamed NB-IoT subframe
// into a ping-pong pilot buffer read by the channel estimator.
module nrs_re_extractor #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [2:0]    v_shift,
    input  logic          re_valid,
    input  logic          re_sof,
    input  logic [DW-1:0] re_i,
    input  logic [DW-1:0] re_q,
    input  logic [2:0]    est_rd_addr,
    input  logic          est_done,
    output logic [DW-1:0] est_rd_i,
    output logic [DW-1:0] est_rd_q,
    output logic          pil_rdy,
    output logic          ovf,
    output logic          sof_err,
    output logic          cfg_err
);
    typedef enum logic {IDLE, FILL} state_t;

    state_t        state_q, state_d;
    logic [3:0]    sc_q, sc_d, sym_q, sym_d;
    logic [2:0]    vs_q, vs_d;
    logic          cfg_err_q, cfg_err_d, pil_rdy_q, pil_rdy_d, pend_q, pend_d;
    logic          rd_bank_q, rd_bank_d, ovf_q, ovf_d, sof_err_q, sof_err_d;
    logic [DW-1:0] est_rd_i_q, est_rd_i_d, est_rd_q_q, est_rd_q_d;
    logic [DW-1:0] mem_i_q [2][8];
    logic [DW-1:0] mem_q_q [2][8];
    logic          sof, rel, comp, we, pil_sym, hit, wbank;
    logic [2:0]    k0, waddr;

    assign wbank = ~rd_bank_q;

    always_comb begin
        state_d    = state_q;
        sc_d       = sc_q;
        sym_d      = sym_q;
        vs_d       = vs_q;
        cfg_err_d  = cfg_err_q;
        pil_rdy_d  = pil_rdy_q;
        pend_d     = pend_q;
        rd_bank_d  = rd_bank_q;
        ovf_d      = 1'b0;
        sof_err_d  = 1'b0;
        we         = 1'b0;
        comp       = 1'b0;
        sof        = re_valid && re_sof;
        rel        = est_done && pil_rdy_q;
        pil_sym    = sym_q == 4'd5 || sym_q == 4'd6 || sym_q == 4'd12 || sym_q == 4'd13;
        k0         = (sym_q == 4'd5 || sym_q == 4'd12) ? vs_q
                   : (vs_q < 3'd3 ? vs_q + 3'd3 : vs_q - 3'd3);
        waddr      = {sym_q >= 4'd7, sym_q == 4'd6 || sym_q == 4'd13, sc_q >= 4'd6};
        if (sof) begin
            sof_err_d = state_q == FILL && (sym_q != 4'd0 || sc_q != 4'd0);
            state_d   = FILL;
            sc_d      = 4'd1;
            sym_d     = 4'd0;
            vs_d      = v_shift > 3'd5 ? 3'd0 : v_shift;
            cfg_err_d = cfg_err_q || v_shift > 3'd5;
        end else if (re_valid && state_q == FILL) begin
            we      = pil_sym && (sc_q == {1'b0, k0} || sc_q == {1'b0, k0} + 4'd6);
            comp    = sym_q == 4'd13 && sc_q == 4'd11;
            sc_d    = sc_q == 4'd11 ? 4'd0 : sc_q + 4'd1;
            sym_d   = sc_q == 4'd11 ? sym_q + 4'd1 : sym_q;
            state_d = comp ? IDLE : FILL;
        end
        if (comp && (!pil_rdy_q || rel)) begin
            rd_bank_d = ~rd_bank_q;
            pil_rdy_d = 1'b1;
        end else if (comp) begin
            pend_d = 1'b1;
        end else if (rel && pend_q) begin
            rd_bank_d = ~rd_bank_q;
            pend_d    = 1'b0;
        end else if (rel) begin
            pil_rdy_d = 1'b0;
        end
        // A new subframe may only overwrite a pending set the estimator never consumed.
        if (sof && pend_d) begin
            ovf_d  = 1'b1;
            pend_d = 1'b0;
        end
        // Read from the bank selected after this edge, forwarding a same-edge pilot write.
        hit        = we && wbank == rd_bank_d && waddr == est_rd_addr;
        est_rd_i_d = hit ? re_i : mem_i_q[rd_bank_d][est_rd_addr];
        est_rd_q_d = hit ? re_q : mem_q_q[rd_bank_d][est_rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sc_q       <= '0;
            sym_q      <= '0;
            vs_q       <= '0;
            cfg_err_q  <= 1'b0;
            pil_rdy_q  <= 1'b0;
            pend_q     <= 1'b0;
            rd_bank_q  <= 1'b0;
            ovf_q      <= 1'b0;
            sof_err_q  <= 1'b0;
            est_rd_i_q <= '0;
            est_rd_q_q <= '0;
            for (int a = 0; a < 8; a++) begin
                mem_i_q[0][a] <= '0;
                mem_i_q[1][a] <= '0;
                mem_q_q[0][a] <= '0;
                mem_q_q[1][a] <= '0;
            end
        end else begin
            state_q    <= state_d;
            sc_q       <= sc_d;
            sym_q      <= sym_d;
            vs_q       <= vs_d;
            cfg_err_q  <= cfg_err_d;
            pil_rdy_q  <= pil_rdy_d;
            pend_q     <= pend_d;
            rd_bank_q  <= rd_bank_d;
            ovf_q      <= ovf_d;
            sof_err_q  <= sof_err_d;
            est_rd_i_q <= est_rd_i_d;
            est_rd_q_q <= est_rd_q_d;
            if (we) begin
                mem_i_q[wbank][waddr] <= re_i;
                mem_q_q[wbank][waddr] <= re_q;
            end
        end
    end

    assign est_rd_i = est_rd_i_q;
    assign est_rd_q = est_rd_q_q;
    assign pil_rdy  = pil_rdy_q;
    assign ovf      = ovf_q;
    assign sof_err  = sof_err_q;
    assign cfg_err  = cfg_err_q;
endmodule

// File: tb/tb_nrs_re_extractor.sv
// tb_nrs_re_extractor: directed-vector bench for the NRS pilot extractor.
module tb_nrs_re_extractor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  v_shift = '0;
    logic        re_valid = 1'b0;
    logic        re_sof = 1'b0;
    logic [15:0] re_i = '0;
    logic [15:0] re_q = '0;
    logic [2:0]  est_rd_addr = '0;
    logic        est_done = 1'b0;
    logic [15:0] est_rd_i, est_rd_q;
    logic        pil_rdy, ovf, sof_err, cfg_err;
    int          n_chk = 0;
    int          n_bad = 0;
    int          ovf_cnt = 0;
    int          sof_err_cnt = 0;
    int          o0, s0;

    nrs_re_extractor #(.DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .v_shift(v_shift), .re_valid(re_valid), .re_sof(re_sof),
        .re_i(re_i), .re_q(re_q), .est_rd_addr(est_rd_addr), .est_done(est_done),
        .est_rd_i(est_rd_i), .est_rd_q(est_rd_q), .pil_rdy(pil_rdy), .ovf(ovf),
        .sof_err(sof_err), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ovf) ovf_cnt++;
        if (sof_err) sof_err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_re(input logic sof, input logic [15:0] val);
        re_valid = 1'b1;
        re_sof   = sof;
        re_i     = val;
        re_q     = ~val;
        @(posedge clk);
        #1;
        re_valid = 1'b0;
        re_sof   = 1'b0;
    endtask

    task automatic send_sf(input logic [2:0] vs, input logic [15:0] base, input int n,
                           input bit gaps, input bit done_last);
        v_shift = vs;
        for (int s = 0; s < 14; s++)
            for (int c = 0; c < 12; c++)
                if (s * 12 + c < n) begin
                    est_done = done_last && s == 13 && c == 11;
                    send_re(s == 0 && c == 0, base + 16'(s * 16 + c));
                    est_done = 1'b0;
                    if (gaps && (s * 12 + c) % 5 == 4) begin
                        @(posedge clk);
                        #1;
                    end
                end
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
        est_rd_addr = a;
        @(posedge clk);
        #1;
        chk(tag, est_rd_i, exp);
    endtask

    task automatic pulse_done();
        est_done = 1'b1;
        @(posedge clk);
        #1;
        est_done = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk("rst_pil_rdy", pil_rdy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_sof_err", sof_err, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_rd_i", est_rd_i, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 168; k++) send_re(1'b0, 16'(k));
        chk("no_sof_ignored", pil_rdy, 0);

        // normal capture, vs=2; addr 7 is written by the completing RE itself
        est_rd_addr = 3'd7;
        send_sf(3'd2, 16'h0000, 168, 1'b0, 1'b0);
        chk("norm_pil_rdy", pil_rdy, 1);
        chk("norm_first_read", est_rd_i, 16'h00DB);
        rd_chk("norm_a0", 3'd0, 16'h0052);
        chk("norm_a0_q", est_rd_q, 16'hFFAD);
        rd_chk("norm_a1", 3'd1, 16'h0058);
        rd_chk("norm_a2", 3'd2, 16'h0065);
        rd_chk("norm_a3", 3'd3, 16'h006B);
        rd_chk("norm_a4", 3'd4, 16'h00C2);
        rd_chk("norm_a5", 3'd5, 16'h00C8);
        rd_chk("norm_a6", 3'd6, 16'h00D5);
        rd_chk("norm_a7", 3'd7, 16'h00DB);
        chk("norm_cfg_err", cfg_err, 0);
        pulse_done();
        chk("norm_release", pil_rdy, 0);

        send_sf(3'd4, 16'h0000, 168, 1'b0, 1'b0);
        rd_chk("vs4_a0", 3'd0, 16'h0054);
        rd_chk("vs4_a2", 3'd2, 16'h0061);
        rd_chk("vs4_a3", 3'd3, 16'h0067);
        chk("vs4_cfg_err", cfg_err, 0);
        pulse_done();

        send_sf(3'd7, 16'h0000, 168, 1'b0, 1'b0);
        chk("vs7_cfg_err", cfg_err, 1);
        rd_chk("vs7_a0", 3'd0, 16'h0050);
        rd_chk("vs7_a2", 3'd2, 16'h0063);
        rd_chk("vs7_a7", 3'd7, 16'h00D9);
        pulse_done();
        chk("vs7_release", pil_rdy, 0);

        // back-pressure
        send_sf(3'd1, 16'h0100, 168, 1'b0, 1'b0);
        send_sf(3'd1, 16'h0200, 168, 1'b0, 1'b0);
        chk("bp_pil_rdy", pil_rdy, 1);
        rd_chk("bp_sf1", 3'd0, 16'h0151);
        est_done = 1'b1;
        est_rd_addr = 3'd0;
        @(posedge clk);
        #1;
        est_done = 1'b0;
        chk("bp_swap_data", est_rd_i, 16'h0251);
        chk("bp_swap_rdy", pil_rdy, 1);
        pulse_done();
        chk("bp_release", pil_rdy, 0);

        // overflow
        o0 = ovf_cnt;
        send_sf(3'd1, 16'h0100, 168, 1'b0, 1'b0);
        send_sf(3'd1, 16'h0200, 168, 1'b0, 1'b0);
        chk("ovf_none_yet", ovf_cnt - o0, 0);
        send_sf(3'd1, 16'h0300, 168, 1'b0, 1'b0);
        chk("ovf_pulse", ovf_cnt - o0, 1);
        rd_chk("ovf_sf1", 3'd0, 16'h0151);
        est_rd_addr = 3'd0;
        pulse_done();
        chk("ovf_sf3", est_rd_i, 16'h0351);
        chk("ovf_rdy", pil_rdy, 1);
        pulse_done();
        chk("ovf_release", pil_rdy, 0);

        // est_done together with the completing RE
        send_sf(3'd1, 16'h0100, 168, 1'b0, 1'b0);
        est_rd_addr = 3'd0;
        send_sf(3'd1, 16'h0400, 168, 1'b0, 1'b1);
        chk("sim_rdy", pil_rdy, 1);
        chk("sim_toggle", est_rd_i, 16'h0451);
        pulse_done();
        chk("sim_release", pil_rdy, 0);

        // SOF at sym 7, restarted subframe streamed with gaps
        s0 = sof_err_cnt;
        o0 = ovf_cnt;
        send_sf(3'd5, 16'h0500, 87, 1'b0, 1'b0);
        send_sf(3'd3, 16'h0600, 168, 1'b1, 1'b0);
        chk("sof_err_pulse", sof_err_cnt - s0, 1);
        chk("sof_no_ovf", ovf_cnt - o0, 0);
        chk("sof_rdy", pil_rdy, 1);
        rd_chk("sof_a0", 3'd0, 16'h0653);
        rd_chk("sof_a3", 3'd3, 16'h0666);
        rd_chk("sof_a4", 3'd4, 16'h06C3);
        pulse_done();

        // reset mid-subframe
        send_sf(3'd0, 16'h0700, 168, 1'b0, 1'b0);
        chk("mrst_pre_rdy", pil_rdy, 1);
        send_sf(3'd0, 16'h0700, 112, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_pil_rdy", pil_rdy, 0);
        chk("mrst_cfg_err", cfg_err, 0);
        chk("mrst_rd_i", est_rd_i, 0);
        chk("mrst_rd_q", est_rd_q, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 112; k < 168; k++) send_re(1'b0, 16'h0700 + 16'(k));
        chk("mrst_ignored", pil_rdy, 0);
        rd_chk("mrst_buf_clear", 3'd0, 16'h0000);
        send_sf(3'd0, 16'h0800, 168, 1'b0, 1'b0);
        chk("mrst_new_rdy", pil_rdy, 1);
        rd_chk("mrst_new_a0", 3'd0, 16'h0850);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/nrs_re_extractor.md
# nrs_re_extractor

Extracts the eight antenna-port-0 narrowband reference signal (NRS) resource elements from each streamed NB-IoT subframe and holds them in a ping-pong pilot buffer for the channel estimator. It sits between the FFT/resource-grid output and channel estimation. It takes `v_shift` (N_cell_ID mod 6) from the NRS index generator and serves random-access pilot reads through `est_rd_addr`.

## Interface
- `DW`, 16, width of each I and Q sample (two's complement)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `v_shift`  in  3  cell frequency shift, legal 0..5; sampled on the accepted SOF RE
- `re_valid`  in  1  RE strobe; one RE accepted per cycle when high
- `re_sof`  in  1  qualifies the accepted RE as symbol 0, subcarrier 0 of a subframe
- `re_i`, `re_q`  in  DW each  RE sample
- `est_rd_addr`  in  3  pilot read address into the read bank
- `est_done`  in  1  one-cycle pulse; estimator releases the read bank
- `est_rd_i`, `est_rd_q`  out  DW each  registered pilot read data
- `pil_rdy`  out  1  read bank holds a complete pilot set
- `ovf`  out  1  one-cycle pulse; a pending pilot set was dropped
- `sof_err`  out  1  one-cycle pulse; SOF arrived mid-subframe
- `cfg_err`  out  1  sticky; latched `v_shift` was greater than 5; cleared only by reset

## Operation
- Grid order: subframe = 14 symbols × 12 subcarriers, symbol-major, subcarrier 0..11 within each symbol. Counters are `sc_cnt` (0..11) and `sym_cnt` (0..13).
- **State IDLE** (reset state): all REs are ignored until an accepted RE has `re_sof=1`.
  - On that RE: counters load to sym 0 / sc 1, `v_shift` latches, state → FILL.
- **State FILL**: each accepted RE advances `sc_cnt`. At `sc_cnt` 11 it wraps to 0 and `sym_cnt` increments.
  - The RE at sym 13 / sc 11 completes the subframe; state → IDLE.
- Latched shift `vs`: if `v_shift` > 5, then `vs` = 0 and `cfg_err` is set.
- Pilot capture into the fill bank, address = {slot, odd symbol, m}:
  - sym 5: k = vs → addr 0; k = vs+6 → addr 1
  - sym 6: k = (vs+3) mod 6 → addr 2; that k + 6 → addr 3
  - sym 12 / sym 13: same rule as sym 5 / sym 6 → addr 4..7
- Banks: two 8-entry × 2·DW arrays. The write-bank pointer and the read-bank pointer are complementary.
- Swap rules:
  - On completion, if `pil_rdy=0`: swap banks, `pil_rdy` → 1.
  - On completion, if `pil_rdy=1`: the fill bank is marked pending, with no swap. When `est_done` next arrives, the swap happens and `pil_rdy` stays 1.
  - `est_done` with nothing pending: `pil_rdy` → 0.
  - `est_done` and completion in the same cycle: release and swap together; `pil_rdy` stays 1 and the read bank toggles.
  - `est_done` while `pil_rdy=0` is ignored.
- SOF mid-subframe (FILL state, `re_sof=1` with counters not at 0/0):
  - `sof_err` pulses.
  - Partial fill is discarded; the fill restarts at sym 0 / sc 1 with a newly latched `vs`.
- Pending set plus new SOF: the pending set is dropped and `ovf` pulses. The new subframe overwrites that bank.
- `est_rd_addr` always reads the current read bank, whether or not `pil_rdy` is high.

## Timing
- Reset values:
  - outputs: `pil_rdy`, `ovf`, `sof_err`, `est_rd_i`, `est_rd_q` = 0; `cfg_err` = 0
  - internal: state = IDLE, pending = 0, read bank = 0, all buffer entries = 0
- Pilot write completes on the rising edge that accepts the RE.
- `pil_rdy` rises one cycle after the completing RE is accepted. It falls one cycle after `est_done` when nothing is pending.
- Read latency: `est_rd_i/q` reflect `est_rd_addr` one cycle later. After a swap, reads see the new bank from the cycle `pil_rdy` is observed high.
- `ovf` and `sof_err` are registered, high for exactly one cycle, one cycle after the causing RE.
- Gaps in `re_valid` are allowed anywhere; counters hold.
- Reset assertion mid-subframe returns everything to reset values immediately. Partial data is lost.

## Test plan
- **Normal capture:** `v_shift`=2, RE value = sym·16+sc, one full subframe, estimator reads addr 0..7. Expect `pil_rdy` high 1 cycle after the last RE; data = sym5 sc2, sym5 sc8, sym6 sc5, sym6 sc11, sym12 sc2, sym12 sc8, sym13 sc5, sym13 sc11.
- **Wrap of (vs+3) mod 6:** `v_shift`=4. Expect sym6 pilots at sc1 and sc7; `v_shift`=7 gives `cfg_err`=1 and capture as with vs=0.
- **Back-pressure:** two subframes with no `est_done`. Expect the second set pending and `pil_rdy` steady. Then `est_done`: next cycle, reads return subframe-2 data and `pil_rdy` stays 1.
- **Overflow:** a third subframe's SOF while a set is pending. Expect an `ovf` pulse, and after two `est_done` pulses only subframes 1 and 3 are read.
- **Simultaneous events:** `est_done` in the same cycle as the completing RE. Expect `pil_rdy` to remain 1 and the read bank to toggle.
- **Corruption and reset:** SOF at sym 7 → `sof_err` pulse and clean capture of the restarted subframe; `rst_n` low at sym 9 → all outputs 0, and REs are ignored until the next SOF.
